multi_timer: RTL and testbench
==============================

# multi_timer

Parametrised multi-channel timer/counter peripheral for the P7 CPU's memory-mapped device bus, sitting behind the bridge alongside the data memory. It generalises the two-instance fixed timer to `NUM_CH` independent channels with configurable counter width. It adds per-channel one-shot, auto-reload and free-running modes, byte-enabled writes, write-1-to-clear interrupt status with mask, and per-channel plus combined interrupt outputs that feed `HWInt`.

## Interface
- `NUM_CH`, 2: number of channels, 1..16.
- `CNT_W`, 32: counter/preset width, 1..32. Registers are zero-extended to 32 bits on read.
- `clk` input 1: single clock, rising-edge.
- `reset` input 1: reset, asynchronous, active-low. Clears all state whenever low.
- `Addr` input 30: byte address bits [31:2].
  - `Addr[1:0]` selects the register.
  - `Addr[5:2]` selects the channel.
  - Higher bits are ignored; the bridge decodes the base.
- `WE` input 1: write strobe, sampled at the clk edge.
- `Byteen` input 4: byte enables for a write. Only enabled bytes change.
- `Din` input 32: write data.
- `Dout` output 32: read data, combinational from `Addr`.
- `IRQ` output NUM_CH: per-channel interrupt, `pending & IM`.
- `IRQ_any` output 1: OR of `IRQ`.

## Operation
- Register map per channel (register select value: name):
  - 0 CTRL: bit0 EN, bits2:1 MODE, bit3 IM. Other bits read 0.
  - 1 PRESET: `CNT_W` bits.
  - 2 COUNT: read-only; writes are ignored.
  - 3 STATUS: bit0 pending. Writing 1 clears it (W1C); writing 0 has no effect.
- Channel index ≥ `NUM_CH`: reads return 0, writes are ignored.
- MODE values:
  - 00: one-shot.
  - 01: auto-reload.
  - 10: free-running up-count.
  - 11: behaves as one-shot.
- Per-channel FSM has four states: IDLE, LOAD, CNT, INT.
  - IDLE: if EN=1, go to LOAD. COUNT holds.
  - LOAD: COUNT <= PRESET, go to CNT.
  - CNT, EN=0: go to IDLE. COUNT holds. Pending is unchanged.
  - CNT, modes 00/01/11: if COUNT==0, go to INT and set pending; else COUNT <= COUNT-1.
  - CNT, mode 10: COUNT <= COUNT+1 mod 2^CNT_W. On wrap (all-ones to 0), set pending. Stays in CNT.
  - INT, one-shot: clear EN, go to IDLE.
  - INT, auto-reload: go to LOAD.
- Simultaneous events:
  - A software CTRL write on the same edge as the one-shot EN clear: the software write wins.
  - W1C on the same edge as hardware set: set wins, pending stays 1.
  - A PRESET write while in CNT takes effect only at the next LOAD.
  - A MODE change while in CNT takes effect from the next edge.
- Partial-byte writes to PRESET merge with the old value. Bits ≥ `CNT_W` are discarded.

## Timing
- Reset (`reset` low, asynchronous):
  - Every channel goes to IDLE.
  - CTRL, PRESET, COUNT and pending are 0.
  - `IRQ`=0 and `IRQ_any`=0 immediately.
  - `Dout` reflects the zeroed registers.
- Reset deassertion is taken at the next clk edge. Reset mid-count aborts with no IRQ.
- Writes: the register updates at the clk edge where WE=1. A read in the same cycle returns the old value.
- One-shot / auto-reload, with PRESET=N and the EN write at edge E:
  - E+1: LOAD.
  - E+2: COUNT=N.
  - E+2+k: COUNT=N-k.
  - E+N+3: INT; pending=1, so `IRQ` is high after this edge if IM=1.
  - E+N+4: one-shot returns to IDLE with EN=0; auto-reload goes to LOAD.
- Auto-reload period is N+3 cycles per pending event.
- PRESET=0: pending sets at E+3.
- Free-running, PRESET=P: COUNT=P at E+2. Wrap occurs at edge E+2+(2^CNT_W - P), and pending sets on that edge.
- `IRQ` stays high until W1C or IM=0. It is level, not pulse.

## Test plan
- Reset: drive `reset`=0 mid-count with pending=1 in channel 0 → `IRQ`=0 and COUNT=0 with no clock edge. After release, all reads return 0.
- One-shot: ch0 PRESET=5, CTRL=0x9 at edge E.
  - COUNT reads 5 at E+2 and 0 at E+7.
  - `IRQ[0]`=1 after E+8; EN reads 0 after E+9.
  - W1C STATUS=1 → `IRQ[0]`=0 next cycle.
- Auto-reload: ch1 PRESET=2, CTRL=0xB, STATUS never cleared. Pending sets every 5 cycles; `IRQ_any`=1. Clear pending at the same edge as a reload set → pending stays 1.
- Free-running with `CNT_W`=8: PRESET=0xFE, CTRL=0x5. COUNT goes 0xFE, 0xFF, 0x00; pending is set on the 0x00 edge and counting continues.
- Bus edges:
  - Byteen=0010 write of 0x0000AB00 to PRESET=0x11223344 → reads 0x1122AB44.
  - A write to COUNT is ignored.
  - Channel index=NUM_CH: reads 0 and writes have no effect.
  - EN=0 written in CNT → COUNT freezes at its current value.
- IM=0: the timer expires, pending=1 but `IRQ`=0. Then set IM=1 → `IRQ` rises the cycle after the write.

Source files
------------

// File: rtl/multi_timer.sv
// Multi-channel memory-mapped timer/counter with one-shot, auto-reload and
// free-running modes, byte-enabled writes and W1C interrupt status per channel.
module multi_timer #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [29:0]       Addr,
  input  logic              WE,
  input  logic [3:0]        Byteen,
  input  logic [31:0]       Din,
  output logic [31:0]       Dout,
  output logic [NUM_CH-1:0] IRQ,
  output logic              IRQ_any
);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, CNT = 2'd2, INT = 2'd3} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  be);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = be[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
    end
    return res;
  endfunction

  logic [NUM_CH-1:0][31:0] rd_word;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    state_t           state;
    logic             en;
    logic [1:0]       mode;
    logic             im;
    logic [CNT_W-1:0] preset;
    logic [CNT_W-1:0] count;
    logic             pending;

    logic             ch_wr;
    logic             ctrl_wr;
    logic             preset_wr;
    logic             w1c;
    logic             hw_set;
    logic [31:0]      preset_ext;
    logic [31:0]      preset_new;
    logic [31:0]      count_ext;
    logic [31:0]      word;

    // Write decode, hardware pending set and read-word selection for this channel
    always_comb begin
      ch_wr      = WE && (Addr[5:2] == 4'(c));
      ctrl_wr    = ch_wr && (Addr[1:0] == 2'd0) && Byteen[0];
      preset_wr  = ch_wr && (Addr[1:0] == 2'd1);
      w1c        = ch_wr && (Addr[1:0] == 2'd3) && Byteen[0] && Din[0];
      preset_ext = 32'h0;
      preset_ext[CNT_W-1:0] = preset;
      count_ext  = 32'h0;
      count_ext[CNT_W-1:0] = count;
      preset_new = merge_bytes(preset_ext, Din, Byteen);
      if (state == CNT && en) begin
        if (mode == 2'b10) begin
          hw_set = &count;
        end else begin
          hw_set = (count == '0);
        end
      end else begin
        hw_set = 1'b0;
      end
      case (Addr[1:0])
        2'd0:    word = {28'h0, im, mode, en};
        2'd1:    word = preset_ext;
        2'd2:    word = count_ext;
        2'd3:    word = {31'h0, pending};
        default: word = 32'h0;
      endcase
    end

    // Channel FSM and register file; a software CTRL write lands after the
    // FSM's one-shot EN clear so it wins, and a hardware set beats W1C.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state   <= IDLE;
        en      <= 1'b0;
        mode    <= 2'b00;
        im      <= 1'b0;
        preset  <= '0;
        count   <= '0;
        pending <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (en) state <= LOAD;
          end
          LOAD: begin
            count <= preset;
            state <= CNT;
          end
          CNT: begin
            if (!en) begin
              state <= IDLE;
            end else if (mode == 2'b10) begin
              count <= count + CNT_ONE;
            end else if (count == '0) begin
              state <= INT;
            end else begin
              count <= count - CNT_ONE;
            end
          end
          INT: begin
            if (mode == 2'b01) begin
              state <= LOAD;
            end else begin
              en    <= 1'b0;
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
        if (ctrl_wr) begin
          en   <= Din[0];
          mode <= Din[2:1];
          im   <= Din[3];
        end
        if (preset_wr) preset <= preset_new[CNT_W-1:0];
        if (hw_set) begin
          pending <= 1'b1;
        end else if (w1c) begin
          pending <= 1'b0;
        end
      end
    end

    assign rd_word[c] = word;
    assign IRQ[c]     = pending & im;
  end

  // Read mux; channel indices beyond NUM_CH match nothing and read as zero
  always_comb begin
    Dout = 32'h0;
    for (int i = 0; i < NUM_CH; i++) begin
      Dout = Dout | ((Addr[5:2] == 4'(i)) ? rd_word[i] : 32'h0);
    end
  end

  assign IRQ_any = |IRQ;

endmodule

// File: tb/tb_multi_timer.sv
// Directed self-checking bench for multi_timer (NUM_CH=2, CNT_W=32).
module tb_multi_timer;

  logic        clk;
  logic        reset;
  logic [29:0] Addr;
  logic        WE;
  logic [3:0]  Byteen;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic [1:0]  IRQ;
  logic        IRQ_any;

  int n_checks = 0;
  int n_errors = 0;

  multi_timer #(.NUM_CH(2), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .Addr(Addr), .WE(WE), .Byteen(Byteen),
    .Din(Din), .Dout(Dout), .IRQ(IRQ), .IRQ_any(IRQ_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_addr(input int ch, input int r);
    Addr = 30'h0;
    Addr[5:2] = 4'(ch);
    Addr[1:0] = 2'(r);
  endtask

  task automatic wr(input int ch, input int r, input logic [31:0] d, input logic [3:0] be);
    set_addr(ch, r);
    Din    = d;
    Byteen = be;
    WE     = 1'b1;
    tick();
    WE     = 1'b0;
    Byteen = 4'h0;
  endtask

  task automatic rd(input string tag, input int ch, input int r, input logic [31:0] exp);
    set_addr(ch, r);
    #1;
    check(tag, Dout, exp);
  endtask

  initial begin
    reset = 1'b0; Addr = 30'h0; WE = 1'b0; Byteen = 4'h0; Din = 32'h0;
    #2;
    check("rst_irq", {30'h0, IRQ}, 32'h0);
    check("rst_irq_any", {31'h0, IRQ_any}, 32'h0);
    rd("rst_ctrl0", 0, 0, 32'h0);
    tick(2);
    reset = 1'b1;
    tick(2);

    // One-shot ch0, PRESET=5, CTRL=0x9 at edge E
    wr(0, 1, 32'd5, 4'hF);
    wr(0, 0, 32'h9, 4'hF);               // edge E
    tick(2);                             // E+2
    rd("os_count_e2", 0, 2, 32'd5);
    tick(5);                             // E+7
    rd("os_count_e7", 0, 2, 32'd0);
    check("os_irq_e7", {30'h0, IRQ}, 32'h0);
    tick();                              // E+8
    check("os_irq_e8", {30'h0, IRQ}, 32'h1);
    rd("os_ctrl_e8", 0, 0, 32'h9);
    tick();                              // E+9
    rd("os_ctrl_e9", 0, 0, 32'h8);
    check("os_irq_e9", {30'h0, IRQ}, 32'h1);
    wr(0, 3, 32'h1, 4'h1);
    check("os_w1c_irq", {30'h0, IRQ}, 32'h0);
    rd("os_w1c_status", 0, 3, 32'h0);

    // Auto-reload ch1, PRESET=2, CTRL=0xB at edge E
    wr(1, 1, 32'd2, 4'hF);
    wr(1, 0, 32'hB, 4'hF);               // edge E
    tick(4);                             // E+4
    rd("ar_status_e4", 1, 3, 32'h0);
    tick();                              // E+5
    rd("ar_status_e5", 1, 3, 32'h1);
    check("ar_irq_any", {31'h0, IRQ_any}, 32'h1);
    check("ar_irq", {30'h0, IRQ}, 32'h2);
    wr(1, 3, 32'h1, 4'h1);               // E+6, plain clear
    rd("ar_clear_e6", 1, 3, 32'h0);
    tick();                              // E+7
    rd("ar_count_e7", 1, 2, 32'd2);
    tick(2);                             // E+9
    rd("ar_status_e9", 1, 3, 32'h0);
    wr(1, 3, 32'h1, 4'h1);               // E+10, clear collides with set
    rd("ar_set_wins", 1, 3, 32'h1);
    wr(1, 0, 32'h0, 4'hF);
    wr(1, 3, 32'h1, 4'h1);
    check("ar_stop_irq_any", {31'h0, IRQ_any}, 32'h0);

    // Free-running ch0 near wrap, IM=0 then IM=1, then freeze with EN=0
    wr(0, 1, 32'hFFFF_FFFE, 4'hF);
    wr(0, 0, 32'h5, 4'hF);               // edge E
    tick(2);                             // E+2
    rd("fr_count_e2", 0, 2, 32'hFFFF_FFFE);
    tick();                              // E+3
    rd("fr_count_e3", 0, 2, 32'hFFFF_FFFF);
    rd("fr_status_e3", 0, 3, 32'h0);
    tick();                              // E+4
    rd("fr_count_wrap", 0, 2, 32'h0);
    rd("fr_status_wrap", 0, 3, 32'h1);
    check("fr_im0_irq", {30'h0, IRQ}, 32'h0);
    tick();                              // E+5
    rd("fr_count_e5", 0, 2, 32'h1);
    wr(0, 0, 32'hD, 4'hF);               // E+6
    check("fr_im1_irq", {30'h0, IRQ}, 32'h1);
    wr(0, 0, 32'h4, 4'hF);               // E+7, count reaches 3 on this edge
    tick(2);
    rd("fr_freeze_count", 0, 2, 32'd3);
    rd("fr_freeze_ctrl", 0, 0, 32'h4);

    // Bus edge cases
    wr(0, 1, 32'h1122_3344, 4'hF);
    wr(0, 1, 32'h0000_AB00, 4'b0010);
    rd("bus_byteen", 0, 1, 32'h1122_AB44);
    wr(0, 2, 32'hDEAD_BEEF, 4'hF);
    rd("bus_count_ro", 0, 2, 32'd3);
    wr(2, 1, 32'h5555_5555, 4'hF);
    rd("bus_ch2_preset", 2, 1, 32'h0);
    rd("bus_ch2_ctrl", 2, 0, 32'h0);
    rd("bus_ch0_untouched", 0, 1, 32'h1122_AB44);
    rd("bus_ch1_untouched", 1, 1, 32'd2);

    // Asynchronous reset while ch0 runs with pending=1
    wr(0, 0, 32'hD, 4'hF);
    check("pre_rst_irq", {30'h0, IRQ}, 32'h1);
    tick(3);
    reset = 1'b0;
    #1;
    check("async_rst_irq", {30'h0, IRQ}, 32'h0);
    check("async_rst_irq_any", {31'h0, IRQ_any}, 32'h0);
    rd("async_rst_count", 0, 2, 32'h0);
    rd("async_rst_status", 0, 3, 32'h0);
    tick(2);
    reset = 1'b1;
    for (int ch = 0; ch < 2; ch++) begin
      tick();
      for (int r = 0; r < 4; r++) begin
        rd($sformatf("post_rst_ch%0d_r%0d", ch, r), ch, r, 32'h0);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
